// File: rtl/systolic_pkg.sv
// Shared defaults and FSM encoding for the systolic array edge feeder.
// Widths here are defaults only; each module carries its own parameters.
package systolic_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_D_W     = 32;
  localparam int DEF_D_W_ACC = 64;
  localparam int DEF_K_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register with synchronous reset.
// Used once per lane to delay the {init, data} word by that lane's skew.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_r [DEPTH];

  // Shift chain: stage 0 captures the input, later stages follow each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_r[k] <= {W{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// West-edge feeder for the MAC systolic array: accepts one tile of operand
// vectors and emits them diagonally skewed, with a per-row init on beat one.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int D_W = DEF_D_W,
  parameter int K_W = DEF_K_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K_W-1:0] k_len,
  input  logic [N*D_W-1:0] s_data,
  input  logic           s_valid,
  output logic           s_ready,
  output logic [N*D_W-1:0] out_a,
  output logic [N-1:0]   out_init,
  output logic           busy,
  output logic           done
);

  // Flush counter only has to reach N-2
  localparam int FC_W = (N > 2) ? $clog2(N - 1) : 1;

  state_t          state_r;
  state_t          next_state_s;
  logic [K_W-1:0]  k_len_r;
  logic [K_W-1:0]  beat_cnt_r;
  logic [FC_W-1:0] flush_cnt_r;
  logic            s_ready_r;
  logic            busy_r;
  logic            done_r;

  logic            accept_s;
  logic            last_beat_s;
  logic            first_beat_s;
  logic            start_ok_s;

  assign accept_s     = s_valid & s_ready_r;
  assign last_beat_s  = accept_s && ((beat_cnt_r + {{(K_W-1){1'b0}}, 1'b1}) == k_len_r);
  assign first_beat_s = accept_s && (beat_cnt_r == {K_W{1'b0}});
  assign start_ok_s   = start && (k_len != {K_W{1'b0}});

  // Next-state decode for the tile sequencer
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          next_state_s = STREAM;
        end else begin
          next_state_s = IDLE;
        end
      end
      STREAM: begin
        if (last_beat_s) begin
          next_state_s = FLUSH;
        end else begin
          next_state_s = STREAM;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == FC_W'(N - 2)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = FLUSH;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      k_len_r     <= {K_W{1'b0}};
      beat_cnt_r  <= {K_W{1'b0}};
      flush_cnt_r <= {FC_W{1'b0}};
      s_ready_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      s_ready_r <= (next_state_s == STREAM);
      busy_r    <= (next_state_s == STREAM) || (next_state_s == FLUSH);
      done_r    <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            k_len_r    <= k_len;
            beat_cnt_r <= {K_W{1'b0}};
          end
        end
        STREAM: begin
          flush_cnt_r <= {FC_W{1'b0}};
          if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + {{(K_W-1){1'b0}}, 1'b1};
          end
        end
        FLUSH: begin
          flush_cnt_r <= flush_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
        end
        default: begin
          flush_cnt_r <= {FC_W{1'b0}};
        end
      endcase
    end
  end

  assign s_ready = s_ready_r;
  assign busy    = busy_r;
  assign done    = done_r;

  // Lane i gets i+1 register stages; non-accepted cycles inject zeros
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [D_W:0] din_s;
    logic [D_W:0] dout_s;

    assign din_s = accept_s ? {first_beat_s, s_data[i*D_W +: D_W]} : {(D_W+1){1'b0}};

    skew_delay_line #(
      .DEPTH (i + 1),
      .W     (D_W + 1)
    ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (din_s),
      .dout (dout_s)
    );

    assign out_a[i*D_W +: D_W] = dout_s[D_W-1:0];
    assign out_init[i]         = dout_s[D_W];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: stimulus pushes expected lane
// words and done edges into queues, a negedge monitor pops and compares.
module tb_systolic_skew_feeder;

  localparam int N   = 4;
  localparam int D_W = 32;
  localparam int K_W = 8;
  localparam int BIG = 1000000;

  logic             clk;
  logic             rst;
  logic             start;
  logic [K_W-1:0]   k_len;
  logic [N*D_W-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [N*D_W-1:0] out_a;
  logic [N-1:0]     out_init;
  logic             busy;
  logic             done;

  systolic_skew_feeder #(.N(N), .D_W(D_W), .K_W(K_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .out_a    (out_a),
    .out_init (out_init),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int             e;
    logic [D_W-1:0] d;
    logic           ini;
  } exp_t;

  exp_t lq [N][$];
  int   dq [$];

  int edge_n  = 0;
  int checks  = 0;
  int failures = 0;
  int busy_lo = 1;
  int busy_hi = 0;
  int rdy_hi  = 0;
  int beats_done = 0;
  int k_cur   = 0;
  bit in_stream = 1'b0;
  int done_e  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  // Start a tile; only called while the feeder is idle
  task automatic start_tile(input int k);
    start = 1'b1;
    k_len = K_W'(k);
    tick();
    start = 1'b0;
    if (k != 0) begin
      in_stream  = 1'b1;
      beats_done = 0;
      k_cur      = k;
      busy_lo    = edge_n;
      busy_hi    = BIG;
      rdy_hi     = BIG;
    end
  endtask

  // Drive one cycle of the stream; record expectations for accepted beats
  task automatic beat(input bit v, input int b);
    s_valid = v;
    for (int i = 0; i < N; i++) s_data[i*D_W +: D_W] = D_W'(10 * b + i);
    tick();
    if (v && in_stream) begin
      for (int i = 0; i < N; i++) begin
        exp_t x;
        x.e   = edge_n + i;
        x.d   = D_W'(10 * b + i);
        x.ini = (beats_done == 0);
        lq[i].push_back(x);
      end
      beats_done++;
      if (beats_done == k_cur) begin
        in_stream = 1'b0;
        done_e    = edge_n + N - 1;
        dq.push_back(done_e);
        busy_hi   = edge_n + N - 2;
        rdy_hi    = edge_n - 1;
      end
    end
  endtask

  // Lane and done monitor
  always @(negedge clk) begin
    logic [D_W-1:0] act_d;
    logic           act_i;
    exp_t           ex;
    for (int i = 0; i < N; i++) begin
      act_d = out_a[i*D_W +: D_W];
      act_i = out_init[i];
      if (lq[i].size() > 0 && lq[i][0].e < edge_n) begin
        checks++;
        failures++;
        $display("FAIL lane%0d_missing edge=%0d required data=%0d at edge %0d", i, edge_n, lq[i][0].d, lq[i][0].e);
        void'(lq[i].pop_front());
      end
      if (act_d !== '0 || act_i !== 1'b0) begin
        checks++;
        if (lq[i].size() == 0) begin
          failures++;
          $display("FAIL lane%0d_unexpected edge=%0d actual data=%0d init=%0b required none", i, edge_n, act_d, act_i);
        end else begin
          ex = lq[i].pop_front();
          if (ex.e != edge_n || ex.d !== act_d || ex.ini !== act_i) begin
            failures++;
            $display("FAIL lane%0d_word edge=%0d actual data=%0d init=%0b required edge=%0d data=%0d init=%0b",
                     i, edge_n, act_d, act_i, ex.e, ex.d, ex.ini);
          end
        end
      end
    end
    if (dq.size() > 0 && dq[0] < edge_n) begin
      checks++;
      failures++;
      $display("FAIL done_missing edge=%0d required at edge %0d", edge_n, dq[0]);
      void'(dq.pop_front());
    end
    if (done !== 1'b0) begin
      checks++;
      if (dq.size() == 0 || dq[0] != edge_n) begin
        failures++;
        $display("FAIL done_unexpected edge=%0d actual done=%0b required 0", edge_n, done);
      end else begin
        void'(dq.pop_front());
      end
    end
  end

  // Per-cycle status monitor for busy and s_ready
  always @(negedge clk) begin
    logic exp_busy;
    logic exp_rdy;
    exp_busy = (edge_n >= busy_lo) && (edge_n <= busy_hi);
    exp_rdy  = (edge_n >= busy_lo) && (edge_n <= rdy_hi);
    checks++;
    if (busy !== exp_busy) begin
      failures++;
      $display("FAIL busy edge=%0d actual=%0b required=%0b", edge_n, busy, exp_busy);
    end
    checks++;
    if (s_ready !== exp_rdy) begin
      failures++;
      $display("FAIL s_ready edge=%0d actual=%0b required=%0b", edge_n, s_ready, exp_rdy);
    end
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    k_len   = '0;
    s_data  = '0;
    s_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic skew, k_len=3, continuous valid
    start_tile(3);
    beat(1'b1, 1);
    beat(1'b1, 2);
    beat(1'b1, 3);
    s_valid = 1'b0;
    idle(N + 3);

    // Bubbles: valid pattern 1,0,0,1,1 with garbage data in bubbles
    start_tile(3);
    beat(1'b1, 1);
    beat(1'b0, 9);
    beat(1'b0, 9);
    beat(1'b1, 2);
    beat(1'b1, 3);
    s_valid = 1'b0;
    idle(N + 3);

    // k_len=0 start is ignored
    start_tile(0);
    beat(1'b1, 7);
    beat(1'b1, 8);
    s_valid = 1'b0;
    idle(3);

    // Back-to-back: tile B starts the cycle after A's done
    start_tile(2);
    beat(1'b1, 1);
    beat(1'b1, 2);
    s_valid = 1'b0;
    while (edge_n < done_e + 1) tick();
    start_tile(2);
    beat(1'b1, 3);
    beat(1'b1, 4);
    s_valid = 1'b0;
    idle(N + 3);

    // Start while busy is ignored; extra valid beats are not taken
    start_tile(2);
    start = 1'b1;
    k_len = 8'd7;
    beat(1'b1, 5);
    start = 1'b0;
    beat(1'b1, 6);
    beat(1'b1, 7);
    beat(1'b1, 8);
    s_valid = 1'b0;
    idle(N + 3);

    // Reset mid-tile discards in-flight data and suppresses done
    start_tile(4);
    beat(1'b1, 1);
    beat(1'b1, 2);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    for (int i = 0; i < N; i++) lq[i].delete();
    dq.delete();
    in_stream = 1'b0;
    busy_hi   = edge_n - 1;
    rdy_hi    = edge_n - 1;
    rst = 1'b0;
    idle(2);
    start_tile(1);
    beat(1'b1, 4);
    s_valid = 1'b0;
    idle(N + 4);

    for (int i = 0; i < N; i++) begin
      checks++;
      if (lq[i].size() != 0) begin
        failures++;
        $display("FAIL lane%0d_drain actual pending=%0d required 0", i, lq[i].size());
      end
    end
    checks++;
    if (dq.size() != 0) begin
      failures++;
      $display("FAIL done_drain actual pending=%0d required 0", dq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
